// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types, standard modes and total helpers
// for the vga_timing_gen pixel timing pipeline.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  typedef struct packed {
    logic req;
    logic h_act;
    logic v_act;
  } vga_ctl_t;

  localparam int CNT_W = 10;

  localparam vga_timing_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
  };

  // 1056 clocks per line: too wide for the 10-bit counters
  localparam vga_timing_t SVGA_800x600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23
  };

  function automatic int unsigned htotal(vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned vtotal(vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register with async reset,
// stage 0 takes d and q is the oldest stage.
module vga_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA counters, sync/blank and strobes,
// realigned to a pixel generator of PIPE enabled cycles latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE      = 2,
  parameter int CW        = 8
) (
  input  logic          vgaclk,
  input  logic          reset_b,
  input  logic          pix_en,
  input  logic [CW-1:0] r_int,
  input  logic [CW-1:0] g_int,
  input  logic [CW-1:0] b_int,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          req,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  localparam vga_timing_t T = '{
    h_active: H_ACTIVE, h_fp: H_FP,
    h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP,
    v_sync: V_SYNC, v_bp: V_BP
  };

  localparam int H_TOTAL = int'(htotal(T));
  localparam int V_TOTAL = int'(vtotal(T));

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
        PIPE > 7 || PIPE < 0) begin : g_bad_cfg
      $error("vga_timing_gen: unsupported timing or PIPE");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // 11-bit bounds so a sync ending at 1024 still compares
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [10:0]      hx;
  logic [10:0]      vx;

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 10'd1;
        end
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign hx = {1'b0, hcnt};
  assign vx = {1'b0, vcnt};

  vga_ctl_t ctl;
  vga_ctl_t ctl_q;

  always_comb begin
    ctl       = '0;
    ctl.req   = (hx < H_ACT) && (vx < V_ACT);
    ctl.h_act = (hx >= H_SS) && (hx < H_SE);
    ctl.v_act = (vx >= V_SS) && (vx < V_SE);
  end

  assign x           = hcnt;
  assign y           = vcnt;
  assign req         = ctl.req;
  assign line_start  = pix_en && (hcnt == '0);
  assign frame_start = pix_en && (hcnt == '0) && (vcnt == '0);

  vga_delay_line #(
    .W     ($bits(vga_ctl_t)),
    .DEPTH (PIPE + 1)
  ) u_dly (
    .clk   (vgaclk),
    .rst_n (reset_b),
    .en    (pix_en),
    .d     (ctl),
    .q     (ctl_q)
  );

  // colour captured on the same edge the final stage loads,
  // so masking with that stage's req matches pre-register gating
  logic [3*CW-1:0] rgb_q;

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      rgb_q <= '0;
    end else if (pix_en) begin
      rgb_q <= {r_int, g_int, b_int};
    end
  end

  assign {r, g, b} = ctl_q.req ? rgb_q : '0;

  assign hsync   = ctl_q.h_act ? HSYNC_POL : ~HSYNC_POL;
  assign vsync   = ctl_q.v_act ? VSYNC_POL : ~VSYNC_POL;
  assign sync_b  = ~(ctl_q.h_act | ctl_q.v_act);
  assign blank_b = ctl_q.req;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reference model pushes expected
// outputs into per-DUT queues, popped as the outputs emerge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 6, AVF = 2, AVS = 2, AVB = 2;
  localparam int AHT = 800, AVT = 12, AP = 2;
  localparam int CHA = 4, CHF = 1, CHS = 1, CHB = 1;
  localparam int CVA = 3, CVF = 1, CVS = 1, CVB = 1;
  localparam int CHT = 7, CVT = 6, CP = 0;

  typedef struct packed {
    logic hs, vs, sb, bb;
    logic [7:0] r, g, b;
  } out_t;

  typedef struct packed {
    logic [9:0] x, y;
    logic req, ls, fs;
  } now_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_c, en_c;
  logic [7:0] ri_a, gi_a, bi_a, ri_c, gi_c, bi_c;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic req_a, ls_a, fs_a, hs_a, vs_a, sb_a, bb_a;
  logic req_b, ls_b, fs_b, hs_b, vs_b, sb_b, bb_b;
  logic req_c, ls_c, fs_c, hs_c, vs_c, sb_c, bb_c;
  logic [7:0] ra, ga, ba, rb, gb, bl, rc, gc, bc;

  vga_timing_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(AP), .CW(8)
  ) u_a (
    .vgaclk(clk), .reset_b(rst_a), .pix_en(en_a),
    .r_int(ri_a), .g_int(gi_a), .b_int(bi_a),
    .x(xa), .y(ya), .req(req_a),
    .line_start(ls_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a), .sync_b(sb_a),
    .blank_b(bb_a), .r(ra), .g(ga), .b(ba)
  );

  vga_timing_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE(AP), .CW(8)
  ) u_b (
    .vgaclk(clk), .reset_b(rst_a), .pix_en(en_a),
    .r_int(ri_a), .g_int(gi_a), .b_int(bi_a),
    .x(xb), .y(yb), .req(req_b),
    .line_start(ls_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b), .sync_b(sb_b),
    .blank_b(bb_b), .r(rb), .g(gb), .b(bl)
  );

  vga_timing_gen #(
    .H_ACTIVE(CHA), .H_FP(CHF), .H_SYNC(CHS), .H_BP(CHB),
    .V_ACTIVE(CVA), .V_FP(CVF), .V_SYNC(CVS), .V_BP(CVB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(CP), .CW(8)
  ) u_c (
    .vgaclk(clk), .reset_b(rst_c), .pix_en(en_c),
    .r_int(ri_c), .g_int(gi_c), .b_int(bi_c),
    .x(xc), .y(yc), .req(req_c),
    .line_start(ls_c), .frame_start(fs_c),
    .hsync(hs_c), .vsync(vs_c), .sync_b(sb_c),
    .blank_b(bb_c), .r(rc), .g(gc), .b(bc)
  );

  // pixel generator with AP cycles of latency for the A/B DUTs
  logic [7:0] pr [AP];
  logic [7:0] pg [AP];
  logic [7:0] pb [AP];

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      for (int i = 0; i < AP; i++) begin
        pr[i] <= 8'h00;
        pg[i] <= 8'h00;
        pb[i] <= 8'h00;
      end
    end else if (en_a) begin
      pr[0] <= (xa == 10'd0 && ya == 10'd0) ? 8'hff : 8'h00;
      pg[0] <= xa[7:0];
      pb[0] <= ya[7:0];
      for (int i = 1; i < AP; i++) begin
        pr[i] <= pr[i-1];
        pg[i] <= pg[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign ri_a = pr[AP-1];
  assign gi_a = pg[AP-1];
  assign bi_a = pb[AP-1];

  assign ri_c = (xc == 10'd0 && yc == 10'd0) ? 8'hff : 8'h00;
  assign gi_c = xc[7:0];
  assign bi_c = yc[7:0];

  int total = 0;
  int bad = 0;
  int mha, mva, mhc, mvc;
  out_t qa[$];
  out_t qc[$];

  int cyc, last_fs, fs_gap, last_ls, ls_gap;
  int max_y, prev_y, x656;
  int hs_start, hs_delay, hs_len;
  int vs_start, vs_delay, vs_len, vs_from_fs;
  int rff_cnt, rff_bad;
  bit y_wrap;
  logic prev_hs, prev_vs;

  function automatic out_t exp_out(
    int h, int v, int ha, int hf, int hw,
    int va_n, int vf, int vw, bit hp, bit vp);
    out_t o;
    bit rq, hact, vact;
    rq   = (h < ha) && (v < va_n);
    hact = (h >= ha + hf) && (h < ha + hf + hw);
    vact = (v >= va_n + vf) && (v < va_n + vf + vw);
    o.hs = hact ? hp : !hp;
    o.vs = vact ? vp : !vp;
    o.sb = !(hact || vact);
    o.bb = rq;
    o.r  = (rq && h == 0 && v == 0) ? 8'hff : 8'h00;
    o.g  = rq ? 8'(h) : 8'h00;
    o.b  = rq ? 8'(v) : 8'h00;
    return o;
  endfunction

  function automatic out_t rst_out(bit hp, bit vp);
    out_t o;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    o.sb = 1'b1;
    return o;
  endfunction

  task automatic clear_stats();
    cyc = 0; last_fs = -1; fs_gap = -1;
    last_ls = -1; ls_gap = -1;
    max_y = 0; prev_y = 0; y_wrap = 0; x656 = -100000;
    hs_start = 0; hs_delay = -1; hs_len = -1;
    vs_start = 0; vs_delay = -1; vs_len = -1;
    vs_from_fs = -1; rff_cnt = 0; rff_bad = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0;
    en_a  = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    mha = 0;
    mva = 0;
    qa.delete();
    repeat (AP + 1) qa.push_back(rst_out(1'b0, 1'b0));
    clear_stats();
  endtask

  task automatic reset_c();
    @(negedge clk);
    rst_c = 1'b0;
    en_c  = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b1;
    mhc = 0;
    mvc = 0;
    qc.delete();
    repeat (CP + 1) qc.push_back(rst_out(1'b0, 1'b0));
  endtask

  // one A/B cycle: compare against the model, then advance it
  task automatic cycle_a(input logic en);
    now_t ne, no;
    out_t eo, oa, eb, ob;
    en_a = en;
    #1;
    cyc++;
    ne.x   = 10'(mha);
    ne.y   = 10'(mva);
    ne.req = (mha < AHA) && (mva < AVA);
    ne.ls  = en && (mha == 0);
    ne.fs  = en && (mha == 0) && (mva == 0);
    no = '{xa, ya, req_a, ls_a, fs_a};
    eo = qa[0];
    oa = '{hs_a, vs_a, sb_a, bb_a, ra, ga, ba};
    total++;
    if (no !== ne || oa !== eo) begin
      bad++;
      $display("FAIL dut_a cyc=%0d got=%h/%h want=%h/%h",
               cyc, no, oa, ne, eo);
    end
    eb = eo;
    eb.hs = !eo.hs;
    ob = '{hs_b, vs_b, sb_b, bb_b, rb, gb, bl};
    total++;
    if (ob !== eb) begin
      bad++;
      $display("FAIL dut_b_pol cyc=%0d got=%h want=%h",
               cyc, ob, eb);
    end
    if (fs_a) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
    if (ls_a) begin
      if (last_ls >= 0) ls_gap = cyc - last_ls;
      last_ls = cyc;
    end
    if (int'(ya) > max_y) max_y = int'(ya);
    if (prev_y == AVT - 1 && ya == 10'd0) y_wrap = 1'b1;
    prev_y = int'(ya);
    if (en && xa == 10'd656) x656 = cyc;
    if (prev_hs && !hs_a) begin
      hs_start = cyc;
      hs_delay = cyc - x656;
    end
    if (!prev_hs && hs_a) hs_len = cyc - hs_start;
    prev_hs = hs_a;
    if (prev_vs && !vs_a) begin
      vs_start   = cyc;
      vs_delay   = cyc - last_ls;
      vs_from_fs = cyc - last_fs;
    end
    if (!prev_vs && vs_a) vs_len = cyc - vs_start;
    prev_vs = vs_a;
    if (ra == 8'hff) begin
      rff_cnt++;
      if (cyc - last_fs != AP + 1) rff_bad++;
    end
    if (en) begin
      qa.push_back(exp_out(mha, mva, AHA, AHF, AHS,
                           AVA, AVF, AVS, 1'b0, 1'b0));
      void'(qa.pop_front());
      mha++;
      if (mha == AHT) begin
        mha = 0;
        mva = (mva == AVT - 1) ? 0 : mva + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle_c(input logic en);
    now_t ne, no;
    out_t eo, oc;
    en_c = en;
    #1;
    ne.x   = 10'(mhc);
    ne.y   = 10'(mvc);
    ne.req = (mhc < CHA) && (mvc < CVA);
    ne.ls  = en && (mhc == 0);
    ne.fs  = en && (mhc == 0) && (mvc == 0);
    no = '{xc, yc, req_c, ls_c, fs_c};
    eo = qc[0];
    oc = '{hs_c, vs_c, sb_c, bb_c, rc, gc, bc};
    total++;
    if (no !== ne || oc !== eo) begin
      bad++;
      $display("FAIL dut_c h=%0d v=%0d got=%h/%h want=%h/%h",
               mhc, mvc, no, oc, ne, eo);
    end
    if (en) begin
      qc.push_back(exp_out(mhc, mvc, CHA, CHF, CHS,
                           CVA, CVF, CVS, 1'b0, 1'b0));
      void'(qc.pop_front());
      mhc++;
      if (mhc == CHT) begin
        mhc = 0;
        mvc = (mvc == CVT - 1) ? 0 : mvc + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    now_t no;
    out_t oa;
    @(negedge clk);
    rst_a = 1'b0;
    en_a  = 1'b1;
    #1;
    no = '{xa, ya, req_a, ls_a, fs_a};
    total++;
    if (no !== now_t'({10'd0, 10'd0, 3'b111})) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", no,
               now_t'({10'd0, 10'd0, 3'b111}));
    end
    oa = '{hs_a, vs_a, sb_a, bb_a, ra, ga, ba};
    total++;
    if (oa !== rst_out(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_out got=%h want=%h", oa,
               rst_out(1'b0, 1'b0));
    end
    total++;
    if (hs_b !== 1'b0 || sb_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_pol got=%b%b want=01", hs_b, sb_b);
    end
    reset_a();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (xa !== 10'(i)) begin
        bad++;
        $display("FAIL x_step got=%0d want=%0d", xa, i);
      end
      cycle_a(1'b1);
    end
  endtask

  task automatic test_frame();
    reset_a();
    repeat (AHT * AVT + 100) cycle_a(1'b1);
    total++;
    if (fs_gap !== AHT * AVT) begin
      bad++;
      $display("FAIL frame_gap got=%0d want=%0d", fs_gap, AHT * AVT);
    end
    total++;
    if (ls_gap !== AHT) begin
      bad++;
      $display("FAIL line_gap got=%0d want=%0d", ls_gap, AHT);
    end
    total++;
    if (max_y !== AVT - 1 || !y_wrap) begin
      bad++;
      $display("FAIL y_wrap got=%0d/%0d want=%0d/1",
               max_y, y_wrap, AVT - 1);
    end
  endtask

  task automatic test_sync();
    reset_a();
    repeat (AHT * AVT + 100) cycle_a(1'b1);
    total++;
    if (hs_len !== AHS || hs_delay !== AP + 1) begin
      bad++;
      $display("FAIL hsync got=%0d/%0d want=%0d/%0d",
               hs_len, hs_delay, AHS, AP + 1);
    end
    total++;
    if (vs_len !== AVS * AHT || vs_delay !== AP + 1) begin
      bad++;
      $display("FAIL vsync got=%0d/%0d want=%0d/%0d",
               vs_len, vs_delay, AVS * AHT, AP + 1);
    end
    total++;
    if (vs_from_fs !== (AVA + AVF) * AHT + AP + 1) begin
      bad++;
      $display("FAIL vsync_line got=%0d want=%0d", vs_from_fs,
               (AVA + AVF) * AHT + AP + 1);
    end
  endtask

  task automatic test_colour();
    reset_a();
    repeat (AHT * AVT + 100) cycle_a(1'b1);
    total++;
    if (rff_cnt !== 2 || rff_bad !== 0) begin
      bad++;
      $display("FAIL red_origin got=%0d/%0d want=2/0",
               rff_cnt, rff_bad);
    end
  endtask

  task automatic test_pix_en();
    reset_a();
    for (int i = 0; i < 2 * AHT * AVT + 100; i++) begin
      cycle_a((i % 2) == 0);
    end
    total++;
    if (fs_gap !== 2 * AHT * AVT) begin
      bad++;
      $display("FAIL half_rate_frame got=%0d want=%0d",
               fs_gap, 2 * AHT * AVT);
    end
    total++;
    if (ls_gap !== 2 * AHT) begin
      bad++;
      $display("FAIL half_rate_line got=%0d want=%0d",
               ls_gap, 2 * AHT);
    end
  endtask

  task automatic test_small_reset();
    int n;
    now_t no;
    out_t oc;
    reset_c();
    n = 0;
    while (!(mhc == 5 && mvc == 2) && n < 500) begin
      cycle_c(1'($urandom_range(0, 1)));
      n++;
    end
    total++;
    if (!(mhc == 5 && mvc == 2)) begin
      bad++;
      $display("FAIL seek_5_2 got=%0d,%0d want=5,2", mhc, mvc);
    end
    en_c = 1'b1;
    #2;
    rst_c = 1'b0;
    #1;
    no = '{xc, yc, req_c, ls_c, fs_c};
    oc = '{hs_c, vs_c, sb_c, bb_c, rc, gc, bc};
    total++;
    if (no !== now_t'({10'd0, 10'd0, 3'b111}) ||
        oc !== rst_out(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL async_reset got=%h/%h want=%h/%h", no, oc,
               now_t'({10'd0, 10'd0, 3'b111}), rst_out(1'b0, 1'b0));
    end
    en_c = 1'b0;
    #1;
    total++;
    if (ls_c !== 1'b0 || fs_c !== 1'b0) begin
      bad++;
      $display("FAIL strobe_en got=%b%b want=00", ls_c, fs_c);
    end
    @(negedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    en_c  = 1'b1;
    mhc = 0;
    mvc = 0;
    qc.delete();
    repeat (CP + 1) qc.push_back(rst_out(1'b0, 1'b0));
    total++;
    if (xc !== 10'd0 || yc !== 10'd0 || bb_c !== 1'b0) begin
      bad++;
      $display("FAIL restart got=%0d,%0d,%b want=0,0,0",
               xc, yc, bb_c);
    end
    cycle_c(1'b1);
    repeat (300) cycle_c(1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst_a = 1'b0;
    rst_c = 1'b0;
    en_a  = 1'b1;
    en_c  = 1'b1;
    clear_stats();
    repeat (2) @(negedge clk);
    test_reset();
    test_frame();
    test_sync();
    test_colour();
    test_pix_en();
    test_small_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage, the next generation of `vgaController`. It produces horizontal/vertical counters, sync, blank and frame/line strobes for any standard mode from porch/sync/active parameters. It realigns sync and blank with the colour returned by a pipelined pixel generator of configurable latency, and supports a pixel-clock enable so it can run from a faster system clock. It sits between the pixel PLL/clock enable and the `videoGen`-style colour generator, driving the video DAC.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HSYNC_POL`, 0: asserted level of `hsync` (0 = active low).
- `VSYNC_POL`, 0: asserted level of `vsync` (0 = active low).
- `PIPE`, 2: latency in enabled cycles from `x`/`y` to `r_int`/`g_int`/`b_int`; range 0..7.
- `CW`, 8: colour channel width.
- `vgaclk` in 1: the single clock; all state is on its rising edge.
- `reset_b` in 1: asynchronous, active-low reset.
- `pix_en` in 1: pixel advance enable; tie high when `vgaclk` is the pixel clock.
- `r_int`, `g_int`, `b_int` in CW each: colour from the generator for the coordinates issued `PIPE` enabled cycles earlier.
- `x`, `y` out 10 each: current pixel coordinates.
- `req` out 1: `x`,`y` lie in the active area.
- `line_start` out 1: first pixel of any line.
- `frame_start` out 1: pixel (0,0).
- `hsync`, `vsync` out 1 each: sync outputs at the programmed polarity.
- `sync_b` out 1: composite sync, active low.
- `blank_b` out 1: low outside the active area.
- `r`, `g`, `b` out CW each: colour to the DAC.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default).
- Elaboration fails (`$error`) if H_TOTAL > 1024, V_TOTAL > 1024, or `PIPE` > 7.
- Line order is active, then front porch, then sync, then back porch. The frame uses the same order.
- `hcnt` counts 0..H_TOTAL-1 and then wraps to 0. The wrap is exact, unlike the inclusive compare in `vgaController`.
- `vcnt` increments only on the cycle `hcnt` wraps, and wraps from V_TOTAL-1 to 0.
- `x` = `hcnt` and `y` = `vcnt`, zero-extended to 10 bits, with no offset subtraction.
- `req` = (hcnt < H_ACTIVE) & (vcnt < V_ACTIVE).
- Sync-active terms, internal:
  - h_act = H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - v_act uses the same form on `vcnt`, so vertical sync edges coincide with `hcnt` = 0.
- `line_start` = pix_en & hcnt==0.
- `frame_start` = pix_en & hcnt==0 & vcnt==0.
- Realignment: `req`, h_act and v_act pass through a delay line of PIPE+1 stages. The colour passes through one output register. The final stage drives:
  - `hsync` = h_act ? HSYNC_POL : ~HSYNC_POL.
  - `vsync` = v_act ? VSYNC_POL : ~VSYNC_POL.
  - `sync_b` = ~(h_act | v_act).
  - `blank_b` = delayed `req`.
  - {r,g,b} = delayed req ? {r_int,g_int,b_int} : 0, registered.
- `pix_en` low: counters, delay line and output register all hold, and the strobes stay low. The generator must stall on the same enable.

## Timing
- Reset, asynchronous and immediate, gives:
  - hcnt = vcnt = 0, so `x` = `y` = 0 and `req` = 1.
  - All delay stages cleared to inactive.
  - `hsync` = ~HSYNC_POL and `vsync` = ~VSYNC_POL.
  - `sync_b` = 1, `blank_b` = 0, r = g = b = 0.
  - `line_start` and `frame_start` equal `pix_en`.
- Release of reset: the first enabled edge advances to hcnt = 1. The output of pixel (0,0) appears PIPE+1 enabled edges after release.
- Latency from `x`,`y` to the matching `r`,`g`,`b`/`hsync`/`vsync`/`blank_b` is exactly PIPE+1 enabled cycles.
- Frame period is H_TOTAL·V_TOTAL enabled cycles; `frame_start` recurs at that interval.
- Reset mid-line restarts at (0,0) and flushes the delay line, so no stale colour or sync reaches the outputs.

## Structure
- Package `vga_pkg` holds:
  - A `vga_timing_t` struct carrying the eight porch/sync/active fields.
  - Constants `VGA_640x480` and `SVGA_800x600`.
  - A `function htotal/vtotal`.
- Sub-module `vga_delay_line #(W, DEPTH)` is an enable-gated, async-reset shift register used for {req, h_act, v_act}.

## Test plan
- Reset held, `pix_en` = 1: `hsync` = `vsync` = 1, `sync_b` = 1, `blank_b` = 0, rgb = 0, `frame_start` = 1. After release, `x` steps 0,1,2….
- Default mode, `pix_en` = 1 → `frame_start` spacing = 420000 cycles; `line_start` spacing = 800 cycles; y reaches 524 then wraps to 0.
- PIPE = 2, `r_int` = FF only when x==0 & y==0 (model generator) → r = FF exactly 3 cycles after `frame_start`, and r = 0 everywhere else.
- `hsync` low for exactly 96 cycles, beginning 3 cycles after x = 656. `vsync` low for 2 lines, from y = 490 to 491, with edges 3 cycles after x = 0. With HSYNC_POL = 1 the `hsync` waveform is inverted while `sync_b` is unchanged.
- `pix_en` toggling 1,0,1,0 → frame period doubles to 840000 cycles; no output changes on disabled cycles.
- Small mode (H 4/1/1/1, V 3/1/1/1): assert `reset_b` low at hcnt = 5, vcnt = 2 → outputs return to reset values immediately, and (0,0) is re-issued on the first enabled edge after release.
